serial_frame_rx: RTL and testbench

Serial frame receiver that sits downstream of the register stage driving the serial line. It synchronizes a single-bit serial input and detects a start bit. It then shifts in DATA_W data bits LSB-first, checks an optional parity bit and the stop bit. It presents the assembled word with a one-cycle VALID pulse and error flags to the parallel consumer.

---
 rtl/serial_frame_rx_if.sv | 24 ++
 rtl/serial_frame_rx.sv | 87 ++++++++
 tb/tb_serial_frame_rx.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Serial frame receiver bus: serial line and strobe in, parallel word and flags out.
interface serial_frame_rx_if #(
   parameter int DATA_W = 8
);
   logic              SIN;
   logic              EN;
   logic [DATA_W-1:0] DATA_OUT;
   logic              VALID;
   logic              PARITY_ERR;
   logic              FRAME_ERR;
   logic              BUSY;

   // Source side: drives the line and bit strobe, observes the received word.
   modport master (
      output SIN, EN,
      input  DATA_OUT, VALID, PARITY_ERR, FRAME_ERR, BUSY
   );

   // Receiver side.
   modport slave (
      input  SIN, EN,
      output DATA_OUT, VALID, PARITY_ERR, FRAME_ERR, BUSY
   );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: 2-flop line synchronizer, start detect, LSB-first data
// shift, optional parity check and stop-bit check. One bit is consumed per EN strobe.
module serial_frame_rx #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic              CLK,
   input  logic              RESET_N,
   serial_frame_rx_if.slave  bus
);
   localparam int   CW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic P_EN  = (PARITY_EN != 0);
   localparam logic P_ODD = (PARITY_ODD != 0);
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;

   logic              sin_m;
   logic              sin_s;
   logic [1:0]        state;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] shift;
   logic              par_bit;

   // Line synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         sin_m <= 1'b1;
         sin_s <= 1'b1;
      end else begin
         sin_m <= bus.SIN;
         sin_s <= sin_m;
      end
   end

   // Frame FSM; flags pulse for one cycle, DATA_OUT holds until the next frame.
   // BUSY tracks the next state so it is high exactly while in DATA/PARITY/STOP.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state          <= IDLE;
         cnt            <= '0;
         shift          <= '0;
         par_bit        <= 1'b0;
         bus.DATA_OUT   <= '0;
         bus.VALID      <= 1'b0;
         bus.PARITY_ERR <= 1'b0;
         bus.FRAME_ERR  <= 1'b0;
         bus.BUSY       <= 1'b0;
      end else begin
         bus.VALID      <= 1'b0;
         bus.PARITY_ERR <= 1'b0;
         bus.FRAME_ERR  <= 1'b0;
         if (bus.EN) begin
            case (state)
               IDLE: begin
                  if (!sin_s) begin
                     state    <= DATA;
                     cnt      <= '0;
                     bus.BUSY <= 1'b1;
                  end
               end
               DATA: begin
                  shift[cnt] <= sin_s;
                  cnt        <= cnt + 1'b1;
                  if (cnt == LAST) state <= P_EN ? PARITY : STOP;
               end
               PARITY: begin
                  par_bit <= sin_s;
                  state   <= STOP;
               end
               default: begin
                  bus.DATA_OUT   <= shift;
                  bus.VALID      <= 1'b1;
                  bus.FRAME_ERR  <= ~sin_s;
                  bus.PARITY_ERR <= P_EN & ((^shift ^ par_bit) != P_ODD);
                  bus.BUSY       <= 1'b0;
                  state          <= IDLE;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: default 8-bit even-parity instance plus a
// 4-bit no-parity instance sharing clock and reset.
module tb_serial_frame_rx;
   logic CLK = 1'b0;
   logic RESET_N;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   serial_frame_rx_if #(.DATA_W(8)) bus8 ();
   serial_frame_rx_if #(.DATA_W(4)) bus4 ();

   serial_frame_rx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0)) dut8 (
      .CLK(CLK), .RESET_N(RESET_N), .bus(bus8.slave));
   serial_frame_rx #(.DATA_W(4), .PARITY_EN(0), .PARITY_ODD(0)) dut4 (
      .CLK(CLK), .RESET_N(RESET_N), .bus(bus4.slave));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // VALID observations, sampled mid-cycle.
   int         vcyc8[$];
   logic [7:0] vdata8[$];
   logic       vperr8[$];
   logic       vferr8[$];
   logic       vbusy8[$];
   int         vcyc4[$];
   logic [3:0] vdata4[$];
   logic       vperr4[$];

   always @(negedge CLK) begin
      if (bus8.VALID === 1'b1) begin
         vcyc8.push_back(cyc);
         vdata8.push_back(bus8.DATA_OUT);
         vperr8.push_back(bus8.PARITY_ERR);
         vferr8.push_back(bus8.FRAME_ERR);
         vbusy8.push_back(bus8.BUSY);
      end
      if (bus4.VALID === 1'b1) begin
         vcyc4.push_back(cyc);
         vdata4.push_back(bus4.DATA_OUT);
         vperr4.push_back(bus4.PARITY_ERR);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_q();
      vcyc8.delete(); vdata8.delete(); vperr8.delete(); vferr8.delete(); vbusy8.delete();
      vcyc4.delete(); vdata4.delete(); vperr4.delete();
   endtask

   // One bit per cycle: start, 8 data LSB-first, parity, stop; line left high.
   task automatic send8(input logic [7:0] d, input logic par, input logic stp);
      bus8.SIN = 1'b0; tick();
      for (int i = 0; i < 8; i++) begin bus8.SIN = d[i]; tick(); end
      bus8.SIN = par; tick();
      bus8.SIN = stp; tick();
      bus8.SIN = 1'b1;
   endtask

   task automatic check_one8(input string nm, input logic [7:0] d, input logic pe, input logic fe);
      checks++;
      if (vcyc8.size() !== 1) begin
         errors++; $display("FAIL %s valid_count got %0d exp 1", nm, vcyc8.size());
      end else begin
         checks++;
         if (vdata8[0] !== d) begin errors++; $display("FAIL %s data got %h exp %h", nm, vdata8[0], d); end
         checks++;
         if (vperr8[0] !== pe) begin errors++; $display("FAIL %s parity_err got %b exp %b", nm, vperr8[0], pe); end
         checks++;
         if (vferr8[0] !== fe) begin errors++; $display("FAIL %s frame_err got %b exp %b", nm, vferr8[0], fe); end
      end
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      bus8.SIN = 1'b1; bus8.EN = 1'b1;
      bus4.SIN = 1'b1; bus4.EN = 1'b1;
      #1;
      checks++;
      if ({bus8.VALID, bus8.BUSY, bus8.PARITY_ERR, bus8.FRAME_ERR, bus8.DATA_OUT} !== 12'h000) begin
         errors++; $display("FAIL reset_outputs got %b exp 0", {bus8.VALID, bus8.BUSY, bus8.PARITY_ERR, bus8.FRAME_ERR, bus8.DATA_OUT});
      end
      repeat (2) tick();
      RESET_N = 1'b1;
      clear_q();
      for (int i = 0; i < 10; i++) begin
         tick();
         checks++;
         if ({bus8.VALID, bus8.BUSY, bus8.PARITY_ERR, bus8.FRAME_ERR, bus8.DATA_OUT} !== 12'h000) begin
            errors++; $display("FAIL idle_outputs cycle %0d got %b exp 0", i, {bus8.VALID, bus8.BUSY, bus8.PARITY_ERR, bus8.FRAME_ERR, bus8.DATA_OUT});
         end
      end
   endtask

   task automatic test_basic();
      int t0;
      clear_q();
      t0 = cyc;
      bus8.SIN = 1'b0; tick();
      for (int i = 0; i < 8; i++) begin
         bus8.SIN = 1'b1 & (8'hA5 >> i); tick();
         if (i == 5) begin
            checks++;
            if (bus8.BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy_mid got %b exp 1", bus8.BUSY); end
         end
      end
      bus8.SIN = 1'b0; tick();
      bus8.SIN = 1'b1; tick();
      repeat (5) tick();
      check_one8("basic", 8'hA5, 1'b0, 1'b0);
      if (vcyc8.size() == 1) begin
         checks++;
         if (vcyc8[0] !== t0 + 13) begin errors++; $display("FAIL basic_latency got %0d exp %0d", vcyc8[0] - t0, 13); end
         checks++;
         if (vbusy8[0] !== 1'b0) begin errors++; $display("FAIL basic_busy_at_valid got %b exp 0", vbusy8[0]); end
      end
      checks++;
      if (bus8.DATA_OUT !== 8'hA5) begin errors++; $display("FAIL basic_data_hold got %h exp a5", bus8.DATA_OUT); end
   endtask

   task automatic test_errors();
      clear_q();
      send8(8'hA5, 1'b1, 1'b1);
      repeat (4) tick();
      check_one8("parity_err", 8'hA5, 1'b1, 1'b0);
      clear_q();
      send8(8'hA5, 1'b0, 1'b0);
      repeat (4) tick();
      check_one8("frame_err", 8'hA5, 1'b0, 1'b1);
      checks++;
      if ({bus8.VALID, bus8.PARITY_ERR, bus8.FRAME_ERR} !== 3'b000) begin
         errors++; $display("FAIL flags_clear got %b exp 000", {bus8.VALID, bus8.PARITY_ERR, bus8.FRAME_ERR});
      end
   endtask

   // Each bit held 4 cycles; EN only on the last so sin_s has settled.
   task automatic test_strobe();
      logic [10:0] bits;
      clear_q();
      bits = {1'b1, 1'b0, 8'h3C, 1'b0};
      for (int b = 0; b < 11; b++) begin
         bus8.SIN = bits[b];
         bus8.EN  = 1'b0;
         repeat (3) tick();
         if (b == 6) begin
            checks++;
            if ({bus8.BUSY, bus8.VALID} !== 2'b10) begin
               errors++; $display("FAIL strobe_hold got %b exp 10", {bus8.BUSY, bus8.VALID});
            end
         end
         bus8.EN = 1'b1; tick();
      end
      bus8.SIN = 1'b1; bus8.EN = 1'b0;
      repeat (4) tick();
      bus8.EN = 1'b1;
      repeat (3) tick();
      check_one8("strobe", 8'h3C, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      clear_q();
      send8(8'h01, 1'b1, 1'b1);
      send8(8'hFE, 1'b1, 1'b1);
      repeat (5) tick();
      checks++;
      if (vcyc8.size() !== 2) begin
         errors++; $display("FAIL b2b_count got %0d exp 2", vcyc8.size());
      end else begin
         checks++;
         if (vcyc8[1] - vcyc8[0] !== 11) begin errors++; $display("FAIL b2b_spacing got %0d exp 11", vcyc8[1] - vcyc8[0]); end
         checks++;
         if (vdata8[0] !== 8'h01) begin errors++; $display("FAIL b2b_data0 got %h exp 01", vdata8[0]); end
         checks++;
         if (vdata8[1] !== 8'hFE) begin errors++; $display("FAIL b2b_data1 got %h exp fe", vdata8[1]); end
         checks++;
         if ({vperr8[0], vferr8[0], vperr8[1], vferr8[1]} !== 4'b0000) begin
            errors++; $display("FAIL b2b_errs got %b exp 0000", {vperr8[0], vferr8[0], vperr8[1], vferr8[1]});
         end
      end
   endtask

   task automatic test_reset_mid();
      clear_q();
      bus8.SIN = 1'b0; tick();
      for (int i = 0; i < 4; i++) begin bus8.SIN = 1'b1 & (8'hA5 >> i); tick(); end
      checks++;
      if (bus8.BUSY !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before got %b exp 1", bus8.BUSY); end
      RESET_N = 1'b0;
      #1;
      checks++;
      if ({bus8.VALID, bus8.BUSY, bus8.PARITY_ERR, bus8.FRAME_ERR, bus8.DATA_OUT} !== 12'h000) begin
         errors++; $display("FAIL rstmid_outputs got %b exp 0", {bus8.VALID, bus8.BUSY, bus8.PARITY_ERR, bus8.FRAME_ERR, bus8.DATA_OUT});
      end
      tick();
      RESET_N = 1'b1;
      bus8.SIN = 1'b1;
      repeat (12) tick();
      checks++;
      if (vcyc8.size() !== 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", vcyc8.size()); end
      send8(8'h5A, 1'b0, 1'b1);
      repeat (4) tick();
      check_one8("rstmid_next", 8'h5A, 1'b0, 1'b0);
   endtask

   task automatic test_noparity();
      int t0;
      logic [3:0] d;
      clear_q();
      d = 4'h9;
      t0 = cyc;
      bus4.SIN = 1'b0; tick();
      for (int i = 0; i < 4; i++) begin bus4.SIN = d[i]; tick(); end
      bus4.SIN = 1'b1; tick();
      repeat (5) tick();
      checks++;
      if (vcyc4.size() !== 1) begin
         errors++; $display("FAIL np_count got %0d exp 1", vcyc4.size());
      end else begin
         checks++;
         if (vcyc4[0] !== t0 + 8) begin errors++; $display("FAIL np_latency got %0d exp 8", vcyc4[0] - t0); end
         checks++;
         if (vdata4[0] !== 4'h9) begin errors++; $display("FAIL np_data got %h exp 9", vdata4[0]); end
         checks++;
         if (vperr4[0] !== 1'b0) begin errors++; $display("FAIL np_parity_err got %b exp 0", vperr4[0]); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_errors();
      test_strobe();
      test_back_to_back();
      test_reset_mid();
      test_noparity();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
